// File: rtl/mimo_distributed_fifo.sv
// -----------------------------------------------------------------------------
// mimo_distributed_fifo
//
// Multi-lane first-word-fall-through FIFO. Each of CHANNELS lanes is an
// independent DEPTH-entry distributed-RAM FIFO with valid/ready handshakes on
// both sides. Each lane reports its registered fill level and almost-full and
// almost-empty flags, and has its own synchronous flush. With LOCKSTEP=1 the
// read side becomes aligned: one word leaves every lane together, and only
// when every lane has data.
//
// Ports:
//   i_clock        clock
//   i_reset        synchronous, active-high reset
//   i_in_data      write data, lane c in bits [c*WIDTH +: WIDTH]
//   i_in_valid     per-lane write valid
//   o_in_ready     per-lane write ready
//   o_out_data     head word of each lane (unregistered RAM read), same packing
//   o_out_valid    per-lane read valid
//   i_out_ready    per-lane read ready (LOCKSTEP=1: only bit 0 is used)
//   i_flush        per-lane synchronous flush
//   o_level        per-lane occupancy, clog2(DEPTH)+1 bits per lane
//   o_almost_full  level >= AFULL_LEVEL
//   o_almost_empty level <= AEMPTY_LEVEL
// -----------------------------------------------------------------------------
module mimo_distributed_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int CHANNELS     = 8,
    parameter int AFULL_LEVEL  = 14,
    parameter int AEMPTY_LEVEL = 2,
    parameter int LOCKSTEP     = 0
) (
    input  logic                                     i_clock,
    input  logic                                     i_reset,
    input  logic [CHANNELS*WIDTH-1:0]                i_in_data,
    input  logic [CHANNELS-1:0]                      i_in_valid,
    output logic [CHANNELS-1:0]                      o_in_ready,
    output logic [CHANNELS*WIDTH-1:0]                o_out_data,
    output logic [CHANNELS-1:0]                      o_out_valid,
    input  logic [CHANNELS-1:0]                      i_out_ready,
    input  logic [CHANNELS-1:0]                      i_flush,
    output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]    o_level,
    output logic [CHANNELS-1:0]                      o_almost_full,
    output logic [CHANNELS-1:0]                      o_almost_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [LW-1:0] DEPTH_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_LVL  = LW'(AFULL_LEVEL);
    localparam logic [LW-1:0] AEMPTY_LVL = LW'(AEMPTY_LEVEL);

    // Storage is deliberately left out of reset so it maps onto distributed RAM.
    logic [WIDTH-1:0] mem_r   [CHANNELS][DEPTH];
    logic [PW-1:0]    head_r  [CHANNELS];
    logic [PW-1:0]    tail_r  [CHANNELS];
    logic [LW-1:0]    level_r [CHANNELS];
    logic             init_r;

    logic                init_s;
    logic [CHANNELS-1:0] lane_ne_s;
    logic [CHANNELS-1:0] in_ready_s;
    logic [CHANNELS-1:0] push_s;
    logic [CHANNELS-1:0] out_valid_s;
    logic [CHANNELS-1:0] pop_s;

    // Write-side handshake and per-lane "has data" terms; ready never looks at valid.
    always_comb begin
        // Blocked both while reset is held and for the one INIT cycle after it.
        init_s = init_r | i_reset;
        for (int c = 0; c < CHANNELS; c++) begin
            lane_ne_s[c]  = (level_r[c] != LW'(0)) && !i_flush[c];
            in_ready_s[c] = !init_s && (level_r[c] != DEPTH_LVL) && !i_flush[c];
            push_s[c]     = in_ready_s[c] & i_in_valid[c];
        end
    end

    if (LOCKSTEP != 0) begin : g_lockstep
        logic all_ne_s;
        logic unused_ready_s;

        // Upper ready bits carry no meaning in aligned mode.
        assign unused_ready_s = ^i_out_ready;

        // Aligned read side: every lane must have data and none may be flushing.
        always_comb begin
            all_ne_s    = !init_s && (&lane_ne_s);
            out_valid_s = {CHANNELS{all_ne_s}};
            pop_s       = {CHANNELS{all_ne_s & i_out_ready[0]}};
        end
    end else begin : g_independent
        // Independent read side per lane.
        always_comb begin
            out_valid_s = {CHANNELS{!init_s}} & lane_ne_s;
            pop_s       = out_valid_s & i_out_ready;
        end
    end

    // RAM write port: one write per lane per accepted push.
    always_ff @(posedge i_clock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (push_s[c]) begin
                mem_r[c][head_r[c]] <= i_in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer, level and INIT-state registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            init_r <= 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
                head_r[c]  <= PW'(0);
                tail_r[c]  <= PW'(0);
                level_r[c] <= LW'(0);
            end
        end else begin
            init_r <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (i_flush[c]) begin
                    head_r[c]  <= PW'(0);
                    tail_r[c]  <= PW'(0);
                    level_r[c] <= LW'(0);
                end else begin
                    if (push_s[c]) begin
                        head_r[c] <= head_r[c] + PW'(1);
                    end
                    if (pop_s[c]) begin
                        tail_r[c] <= tail_r[c] + PW'(1);
                    end
                    // Simultaneous push and pop leaves the level unchanged.
                    case ({push_s[c], pop_s[c]})
                        2'b10:   level_r[c] <= level_r[c] + LW'(1);
                        2'b01:   level_r[c] <= level_r[c] - LW'(1);
                        default: level_r[c] <= level_r[c];
                    endcase
                end
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_out
        assign o_out_data[c*WIDTH +: WIDTH] = mem_r[c][tail_r[c]];
        assign o_level[c*LW +: LW]          = level_r[c];
        assign o_almost_full[c]             = (level_r[c] >= AFULL_LVL);
        assign o_almost_empty[c]            = (level_r[c] <= AEMPTY_LVL);
    end

    assign o_in_ready  = in_ready_s;
    assign o_out_valid = out_valid_s;

endmodule

// File: doc/mimo_distributed_fifo.md
Name: mimo_distributed_fifo

Overview:
- Multi-channel first-word-fall-through FIFO for the MIMO datapath: CHANNELS independent lanes, each a DEPTH-entry distributed-RAM FIFO with valid/ready on both sides.
- Next generation of the single-lane distributed FIFO. Adds full DEPTH-entry capacity, per-lane fill level, almost-full/almost-empty flags, per-lane synchronous flush, and an optional lockstep output mode that releases one word from every lane together.

Parameters:
- WIDTH, 8, data bits per lane
- DEPTH, 16, entries per lane; power of 2, >= 2
- CHANNELS, 8, number of lanes, >= 1
- AFULL_LEVEL, 14, o_almost_full asserts when level >= this; range 1..DEPTH
- AEMPTY_LEVEL, 2, o_almost_empty asserts when level <= this; range 0..DEPTH-1
- LOCKSTEP, 0, 0 = independent lane outputs; 1 = aligned output across all lanes

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_in_data  in  CHANNELS*WIDTH  write data; lane c occupies bits [c*WIDTH +: WIDTH]
- i_in_valid  in  CHANNELS  per-lane write valid
- o_in_ready  out  CHANNELS  per-lane write ready
- o_out_data  out  CHANNELS*WIDTH  head word of each lane, same packing as i_in_data
- o_out_valid  out  CHANNELS  per-lane read valid
- i_out_ready  in  CHANNELS  per-lane read ready; in LOCKSTEP=1 only bit 0 is used
- i_flush  in  CHANNELS  per-lane synchronous flush
- o_level  out  CHANNELS*(clog2(DEPTH)+1)  per-lane registered occupancy
- o_almost_full  out  CHANNELS  level >= AFULL_LEVEL
- o_almost_empty  out  CHANNELS  level <= AEMPTY_LEVEL

Behaviour:
- Reset: i_reset is synchronous, active-high, on clock i_clock.
  - Clears all head/tail pointers and levels to 0. Buffer RAM is not cleared.
  - While in reset and for exactly 1 cycle after deassertion (INIT state): o_in_ready = 0, o_out_valid = 0.
  - Levels read 0, o_almost_empty = 1, o_almost_full = 0.
- Pointers are clog2(DEPTH) bits and wrap naturally (DEPTH-1 -> 0). Level is clog2(DEPTH)+1 bits, range 0..DEPTH.
- Push on lane c = i_in_valid[c] & o_in_ready[c]; the word is written at head and head increments.
  - o_in_ready[c] = !INIT & (level[c] < DEPTH) & !i_flush[c].
  - Depends only on registered state and i_flush; never on i_in_valid.
- Pop on lane c (LOCKSTEP=0) = o_out_valid[c] & i_out_ready[c]; tail increments.
  - o_out_valid[c] = !INIT & (level[c] != 0) & !i_flush[c].
- LOCKSTEP=1:
  - all_ne = every lane has level != 0 and no lane is flushing.
  - o_out_valid[c] = all_ne for every c.
  - A pop happens on all lanes simultaneously iff all_ne & i_out_ready[0]. i_out_ready[CHANNELS-1:1] are ignored.
  - Inputs stay independent per lane.
- Output data: o_out_data is an unregistered read of buffer[tail].
  - A word pushed in cycle N is visible with valid in cycle N+1 (1-cycle fall-through), including when the lane was empty.
- Level update per lane:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged; both pointers advance.
  - No push is possible when full and no pop when empty, so no overflow or underflow.
- Flush: i_flush[c] high in cycle N sets head = tail = 0 and level = 0 for lane c at the edge ending cycle N.
  - In cycle N lane c shows in_ready = 0 and valid = 0, so no handshake completes.
  - Other lanes are unaffected. In LOCKSTEP=1, any flushing lane holds all_ne low.
  - Multi-cycle flush holds the lane empty.
- Flags: combinational compare of registered level; no extra latency beyond the level register.
- Reset mid-operation: all contents are discarded. Behaviour is identical to power-on reset, including the 1-cycle INIT.

Test Plan (WIDTH=8, DEPTH=4, CHANNELS=2, AFULL_LEVEL=3, AEMPTY_LEVEL=1, LOCKSTEP=0 unless stated):
- Reset, then push 0x11,0x12,0x13,0x14 on lane 0 with i_out_ready=0 -> o_in_ready[0]=0 after the 4th accept, o_level[0]=4, o_almost_full[0]=1 from level 3; lane 1 level 0, o_in_ready[1]=1.
- Drain lane 0 with i_out_ready[0]=1 -> o_out_data lane 0 = 0x11,0x12,0x13,0x14 on consecutive cycles; then o_out_valid[0]=0, o_almost_empty[0]=1.
- Lane 0 at level 2, push and pop together for 10 cycles with incrementing data -> o_level[0] stays 2, output order strictly incrementing across pointer wrap.
- LOCKSTEP=1: lane 0 holds 3 words, lane 1 empty -> o_out_valid=2'b00. Push one word to lane 1 -> next cycle o_out_valid=2'b11. With i_out_ready=2'b01 for one cycle -> levels become 2 and 0, o_out_valid=2'b00.
- Lane 1 at level 3, assert i_flush[1] for 1 cycle while i_in_valid[1]=1 -> o_in_ready[1]=0 in that cycle; next cycle o_level[1]=0 and o_out_valid[1]=0; lane 0 level and data unchanged.
- Both lanes at level 2, assert i_reset for 1 cycle -> the next cycle shows o_in_ready=2'b00, o_out_valid=2'b00, levels 0; the following cycle o_in_ready=2'b11.
